// File: rtl/vfm_periph_input_ctrl.sv
// Push-button input controller for the VFM core input peripheral port.
// Synchronizes a raw active-low button and a 4-bit DIP switch, debounces the button,
// and on each accepted press captures the DIP value and emits a single write strobe.
// Optional build macro: VFM_INPUT_SEQ_TAG_EN adds a 4-bit sequence tag in bits [13:10].
module vfm_periph_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic        Clock_pin,
  input  logic        Resetn_pin,
  input  logic        Button_n,
  input  logic [3:0]  Dip_sw,
  output logic [13:0] Peripheral_input,
  output logic        Input_write,
  output logic        Busy
);

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StWaitRelease
  } state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             btn_meta_q, btn_sync_q;
  logic [3:0]       dip_meta_q, dip_sync_q;
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_e           state_q, state_d;
  logic             capture;
  logic [3:0]       data_q;
  logic             write_q, busy_q;
  logic [3:0]       tag;

  // Two-flop synchronizers; button idles released (1), DIP idles 0.
  always_ff @(posedge Clock_pin or negedge Resetn_pin) begin
    if (!Resetn_pin) begin
      btn_meta_q <= 1'b1;
      btn_sync_q <= 1'b1;
      dip_meta_q <= 4'h0;
      dip_sync_q <= 4'h0;
    end else begin
      btn_meta_q <= Button_n;
      btn_sync_q <= btn_meta_q;
      dip_meta_q <= Dip_sw;
      dip_sync_q <= dip_meta_q;
    end
  end

  // Debounce: count consecutive disagreeing samples; any agreeing sample restarts the count.
  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (btn_sync_q != deb_q) begin
      if (cnt_q == CntLast) begin
        deb_d = ~deb_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debounce state register.
  always_ff @(posedge Clock_pin or negedge Resetn_pin) begin
    if (!Resetn_pin) begin
      deb_q <= 1'b1;
      cnt_q <= '0;
    end else begin
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  // Press FSM next state; capture marks the IDLE->WRITE edge.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!deb_q) begin
          state_d = StWrite;
          capture = 1'b1;
        end
      end
      StWrite:       state_d = StWaitRelease;
      StWaitRelease: if (deb_q) state_d = StIdle;
      default:       state_d = StIdle;
    endcase
  end

  // FSM state, captured data, and registered strobe/busy (both lag the state by one cycle).
  always_ff @(posedge Clock_pin or negedge Resetn_pin) begin
    if (!Resetn_pin) begin
      state_q <= StIdle;
      data_q  <= 4'h0;
      write_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) data_q <= dip_sync_q;
      write_q <= (state_q == StWrite);
      busy_q  <= (state_q != StIdle);
    end
  end

`ifdef VFM_INPUT_SEQ_TAG_EN
  logic [3:0] tag_q;

  // Sequence tag advances with each capture so the first write carries tag 1; wraps naturally.
  always_ff @(posedge Clock_pin or negedge Resetn_pin) begin
    if (!Resetn_pin) begin
      tag_q <= 4'h0;
    end else if (capture) begin
      tag_q <= tag_q + 4'd1;
    end
  end

  assign tag = tag_q;
`else
  assign tag = 4'h0;
`endif

  assign Peripheral_input = {tag, 6'b00_0000, data_q};
  assign Input_write      = write_q;
  assign Busy             = busy_q;

endmodule

// File: tb/tb_vfm_periph_input_ctrl.sv
// Directed self-checking bench for vfm_periph_input_ctrl with DEBOUNCE_CYCLES=4, CNT_W=3.
// Define VFM_INPUT_SEQ_TAG_EN for both bench and RTL to check the sequence-tag build.
module tb_vfm_periph_input_ctrl;

`ifdef VFM_INPUT_SEQ_TAG_EN
  localparam bit TagEn = 1'b1;
`else
  localparam bit TagEn = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        button_n;
  logic [3:0]  dip_sw;
  logic [13:0] periph;
  logic        input_write;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  vfm_periph_input_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .Clock_pin       (clk),
    .Resetn_pin      (rst_n),
    .Button_n        (button_n),
    .Dip_sw          (dip_sw),
    .Peripheral_input(periph),
    .Input_write     (input_write),
    .Busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [3:0] dip, input logic [3:0] seq);
    logic [13:0] w;
    w = TagEn ? {seq, 6'b00_0000, dip} : {4'h0, 6'b00_0000, dip};
    return {18'h0, w};
  endfunction

  // Advance one clock edge and settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run n edges (edge 0 is the first after the call), recording strobe and busy activity.
  task automatic run_edges(input int n, output int pulses, output int first_at,
                           output int busy_hi);
    pulses   = 0;
    first_at = -1;
    busy_hi  = 0;
    for (int e = 0; e < n; e++) begin
      tick();
      if (input_write) begin
        pulses++;
        if (first_at < 0) first_at = e;
      end
      if (busy) busy_hi++;
    end
  endtask

  initial begin
    int p, f, b, p2, f2, b2;
    logic [3:0] d;

    rst_n    = 1'b0;
    button_n = 1'b1;
    dip_sw   = 4'h0;
    tick();
    tick();
    check_eq("reset_periph", 32'(periph), 32'h0);
    check_eq("reset_write", 32'(input_write), 32'h0);
    check_eq("reset_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    dip_sw = 4'hA;
    run_edges(3, p, f, b);

    // Held press: one strobe, 7 edges after the first stable sample.
    button_n = 1'b0;
    run_edges(20, p, f, b);
    check_eq("hold_pulses", 32'(p), 32'd1);
    check_eq("hold_latency", 32'(f), 32'd7);
    check_eq("hold_periph", 32'(periph), exp_word(4'hA, 4'd1));
    check_eq("hold_busy", 32'(busy), 32'd1);
    button_n = 1'b1;
    run_edges(7, p, f, b);
    check_eq("rel_busy_still_hi", 32'(busy), 32'd1);
    tick();
    check_eq("rel_busy_lo", 32'(busy), 32'd0);

    // Three-cycle glitch: too short to be accepted; DIP change ignored.
    dip_sw   = 4'hF;
    button_n = 1'b0;
    run_edges(3, p, f, b);
    button_n = 1'b1;
    run_edges(15, p2, f2, b2);
    check_eq("glitch_pulses", 32'(p + p2), 32'd0);
    check_eq("glitch_busy", 32'(b + b2), 32'd0);
    check_eq("glitch_periph", 32'(periph), exp_word(4'hA, 4'd1));

    // DIP changes while held must not alter captured data.
    dip_sw   = 4'h3;
    button_n = 1'b0;
    run_edges(12, p, f, b);
    check_eq("dip_pulses", 32'(p), 32'd1);
    dip_sw = 4'hC;
    run_edges(8, p, f, b);
    check_eq("dip_no_extra", 32'(p), 32'd0);
    check_eq("dip_held_periph", 32'(periph), exp_word(4'h3, 4'd2));
    button_n = 1'b1;
    run_edges(7, p, f, b);
    check_eq("dip_rel_busy_hi", 32'(busy), 32'd1);
    tick();
    check_eq("dip_rel_busy_lo", 32'(busy), 32'd0);
    check_eq("dip_rel_periph", 32'(periph), exp_word(4'h3, 4'd2));

    // Bounce: alternate every 2 cycles for 10 cycles, then stay low (stable from edge 8).
    dip_sw = 4'h6;
    p = 0;
    f = -1;
    for (int i = 0; i < 40; i++) begin
      button_n = (i < 10) ? logic'(((i / 2) % 2) == 1) : 1'b0;
      tick();
      if (input_write) begin
        p++;
        if (f < 0) f = i;
      end
    end
    check_eq("bounce_pulses", 32'(p), 32'd1);
    check_eq("bounce_edge", 32'(f), 32'd15);
    check_eq("bounce_periph", 32'(periph), exp_word(4'h6, 4'd3));
    button_n = 1'b1;
    run_edges(10, p, f, b);
    check_eq("bounce_idle", 32'(busy), 32'd0);

    // Reset during WAIT_RELEASE with the button held.
    dip_sw   = 4'h5;
    button_n = 1'b0;
    run_edges(10, p, f, b);
    check_eq("rst_pre_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_periph", 32'(periph), 32'h0);
    check_eq("rst_async_write", 32'(input_write), 32'h0);
    check_eq("rst_async_busy", 32'(busy), 32'h0);
    tick();
    rst_n = 1'b1;
    run_edges(12, p, f, b);
    check_eq("rst_new_pulses", 32'(p), 32'd1);
    check_eq("rst_new_latency", 32'(f), 32'd7);
    check_eq("rst_new_periph", 32'(periph), exp_word(4'h5, 4'd1));
    button_n = 1'b1;
    run_edges(10, p, f, b);

    // 17 press/release cycles from reset: tags 1..15, 0, 1 (zero without the tag build).
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int k = 1; k <= 17; k++) begin
      d        = 4'(k) ^ 4'h9;
      dip_sw   = d;
      button_n = 1'b0;
      run_edges(10, p, f, b);
      check_eq($sformatf("seq%0d_pulses", k), 32'(p), 32'd1);
      check_eq($sformatf("seq%0d_periph", k), 32'(periph), exp_word(d, 4'(k)));
      button_n = 1'b1;
      run_edges(10, p, f, b);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
